fpm_hit_extractor: RTL and testbench

- Downstream consumer of the fast-pattern-matcher shift-or filter output.
- Takes each 256-bit per-beat result vector, where a 0 bit means a candidate hit, and the packet framing delayed to align with it.
- Buffers the beats, then serialises every candidate hit into a (byte offset, bucket) stream with valid/ready backpressure.
- Closes each packet with an end token, which the rule-matching stage uses to fetch candidates.

---
 rtl/fpm_pkg.sv | 32 +++
 rtl/fpm_ffz.sv | 28 ++
 rtl/fpm_hit_extractor.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fpm_hit_extractor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// -----------------------------------------------------------------------------
// fpm_pkg
// Shared definitions for the fast-pattern-matcher hit extractor.
//   FP_DWIDTH    : filter vector width (FP_LANES byte lanes x FP_BUCKETS buckets)
//   FP_IDX_W     : width of a bit index into the filter vector
//   FP_POS_WIDTH : default byte-offset width of the hit stream
//   fpm_beat_t   : one buffered beat (filter vector plus framing and trunc flag)
//   fpm_hit_t    : one entry of the hit stream handed to rule matching
// -----------------------------------------------------------------------------
package fpm_pkg;

    localparam int FP_LANES     = 32;
    localparam int FP_BUCKETS   = 8;
    localparam int FP_DWIDTH    = FP_LANES * FP_BUCKETS;
    localparam int FP_IDX_W     = $clog2(FP_DWIDTH);
    localparam int FP_POS_WIDTH = 16;

    typedef struct packed {
        logic [FP_DWIDTH-1:0] vector;  // active-low candidate bits
        logic                 sop;
        logic                 eop;
        logic                 trunc;   // set only on overflow end tokens
    } fpm_beat_t;

    typedef struct packed {
        logic [FP_POS_WIDTH-1:0] pos;
        logic [2:0]              bucket;
        logic                    last;
        logic                    trunc;
    } fpm_hit_t;

endpackage

// File: rtl/fpm_ffz.sv
// -----------------------------------------------------------------------------
// fpm_ffz
// Combinational find-first-zero over one filter vector.
//   vec      : filter vector, a 0 bit marks a candidate hit
//   idx      : index of the lowest 0 bit (0 when there is none)
//   all_ones : no 0 bit present
// -----------------------------------------------------------------------------
module fpm_ffz
    import fpm_pkg::*;
(
    input  logic [FP_DWIDTH-1:0] vec,
    output logic [FP_IDX_W-1:0]  idx,
    output logic                 all_ones
);

    // Walk from the top down so the last assignment is the lowest zero.
    always_comb begin
        idx      = '0;
        all_ones = 1'b1;
        for (int i = FP_DWIDTH - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                idx      = FP_IDX_W'(i);
                all_ones = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fpm_hit_extractor.sv
// -----------------------------------------------------------------------------
// fpm_hit_extractor
// Buffers shift-or filter beats and serialises every candidate hit (0 bit) as
// a (byte offset, bucket) stream, closing each packet with an end token.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid      filter vector per beat, bit = lane*8 + bucket
//   in_sop/in_eop         packet framing aligned with in_data
//   out_valid/out_ready   hit stream handshake
//   out_pos/out_bucket    byte offset (beat_idx*32 + lane) and bucket
//   out_last/out_trunc    end token, trunc marks a packet cut by overflow
//   stat_hits/stat_drops  counters, present only with FPM_HIT_STATS_EN defined
//
// Handshake: out_* are registers; an entry is transferred on a cycle where
// out_valid & out_ready. While out_valid & !out_ready every out_* holds, and
// out_valid only falls after a transfer. Upstream has no backpressure.
//
// Optional build macro: FPM_HIT_STATS_EN enables the statistic counters.
// -----------------------------------------------------------------------------
module fpm_hit_extractor
    import fpm_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int POS_WIDTH  = FP_POS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FP_DWIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [POS_WIDTH-1:0] out_pos,
    output logic [2:0]           out_bucket,
    output logic                 out_last,
    output logic                 out_trunc,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_drops
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = POS_WIDTH - 5;
    localparam logic [BW-1:0] BEAT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_END} state_t;

    state_t               state_q, state_d;
    logic [FP_DWIDTH-1:0] w_q, w_d, w_next, hit_mask;
    logic                 cur_eop_q, cur_eop_d, cur_trunc_q, cur_trunc_d;
    logic [BW-1:0]        beat_idx_q, beat_idx_d, base_idx;
    logic                 beat_ovf_q, beat_ovf_d, base_ovf;
    logic                 out_valid_q, out_valid_d;
    logic [POS_WIDTH-1:0] out_pos_q, out_pos_d;
    logic [2:0]           out_bucket_q, out_bucket_d;
    logic                 out_last_q, out_last_d, out_trunc_q, out_trunc_d;
    logic                 drop_q, drop_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    fpm_beat_t            mem_q [FIFO_DEPTH];
    fpm_beat_t            head, push_beat;
    logic                 push, pop, fifo_empty, room, not_full, slot_free;
    logic [FP_DWIDTH-1:0] ffz_vec;
    logic [FP_IDX_W-1:0]  ffz_idx;
    logic                 ffz_all;

    // Returns {overflow, index}; once the index saturates, later beats overflow.
    function automatic logic [BW:0] beat_advance(input logic [BW-1:0] idx, input logic ovf);
        if (idx == BEAT_MAX) return {1'b1, idx};
        return {ovf, idx + BW'(1)};
    endfunction

    assign fifo_empty = (count_q == '0);
    assign room       = (count_q <= CW'(FIFO_DEPTH - 2));
    assign not_full   = (count_q != CW'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign slot_free  = !out_valid_q || out_ready;

    // IDLE looks at the FIFO head so all-ones beats are skipped in one cycle.
    assign ffz_vec = (state_q == ST_IDLE) ? head.vector : w_q;

    fpm_ffz u_ffz (
        .vec      (ffz_vec),
        .idx      (ffz_idx),
        .all_ones (ffz_all)
    );

    // Enqueue: one slot is held back so an overflow end token always fits.
    always_comb begin
        push      = 1'b0;
        drop_d    = drop_q;
        push_beat = '{vector: in_data, sop: in_sop, eop: in_eop, trunc: 1'b0};
        if (in_valid) begin
            if (drop_q && !(in_sop && !in_eop)) begin
                if (in_eop) begin
                    push      = not_full;
                    push_beat = '{vector: '1, sop: in_sop, eop: 1'b1, trunc: 1'b1};
                    drop_d    = 1'b0;
                end
            end else begin
                // A bare sop during drop mode is a framing error: resume normally.
                drop_d = 1'b0;
                if (room) begin
                    push = 1'b1;
                end else if (in_eop) begin
                    push      = not_full;
                    push_beat = '{vector: '1, sop: in_sop, eop: 1'b1, trunc: 1'b1};
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        cur_eop_d    = cur_eop_q;
        cur_trunc_d  = cur_trunc_q;
        beat_idx_d   = beat_idx_q;
        beat_ovf_d   = beat_ovf_q;
        out_valid_d  = out_valid_q;
        out_pos_d    = out_pos_q;
        out_bucket_d = out_bucket_q;
        out_last_d   = out_last_q;
        out_trunc_d  = out_trunc_q;
        pop          = 1'b0;
        hit_mask     = '0;
        hit_mask[ffz_idx] = 1'b1;
        w_next       = w_q | hit_mask;
        base_idx     = head.sop ? '0 : beat_idx_q;
        base_ovf     = head.sop ? 1'b0 : beat_ovf_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    cur_eop_d   = head.eop;
                    cur_trunc_d = head.trunc;
                    beat_idx_d  = base_idx;
                    beat_ovf_d  = base_ovf;
                    if (!ffz_all) begin
                        w_d     = head.vector;
                        state_d = ST_SCAN;
                    end else if (head.eop) begin
                        state_d = ST_END;
                    end else begin
                        {beat_ovf_d, beat_idx_d} = beat_advance(base_idx, base_ovf);
                    end
                end
            end
            ST_SCAN: begin
                // A hit is retired when it is loaded into the output register.
                if (slot_free) begin
                    out_valid_d  = 1'b1;
                    out_pos_d    = beat_ovf_q ? '1 : {beat_idx_q, ffz_idx[FP_IDX_W-1:3]};
                    out_bucket_d = ffz_idx[2:0];
                    out_last_d   = 1'b0;
                    out_trunc_d  = 1'b0;
                    w_d          = w_next;
                    if (&w_next) begin
                        if (cur_eop_q) begin
                            state_d = ST_END;
                        end else begin
                            {beat_ovf_d, beat_idx_d} = beat_advance(beat_idx_q, beat_ovf_q);
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_END: begin
                if (slot_free) begin
                    out_valid_d  = 1'b1;
                    out_pos_d    = '0;
                    out_bucket_d = '0;
                    out_last_d   = 1'b1;
                    out_trunc_d  = cur_trunc_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            w_q          <= '1;
            cur_eop_q    <= 1'b0;
            cur_trunc_q  <= 1'b0;
            beat_idx_q   <= '0;
            beat_ovf_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pos_q    <= '0;
            out_bucket_q <= '0;
            out_last_q   <= 1'b0;
            out_trunc_q  <= 1'b0;
            drop_q       <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            cur_eop_q    <= cur_eop_d;
            cur_trunc_q  <= cur_trunc_d;
            beat_idx_q   <= beat_idx_d;
            beat_ovf_q   <= beat_ovf_d;
            out_valid_q  <= out_valid_d;
            out_pos_q    <= out_pos_d;
            out_bucket_q <= out_bucket_d;
            out_last_q   <= out_last_d;
            out_trunc_q  <= out_trunc_d;
            drop_q       <= drop_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Beat storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_beat;
    end

    assign out_valid  = out_valid_q;
    assign out_pos    = out_pos_q;
    assign out_bucket = out_bucket_q;
    assign out_last   = out_last_q;
    assign out_trunc  = out_trunc_q;

`ifdef FPM_HIT_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d, stat_drops_q, stat_drops_d;

    // A beat counts as dropped when it leaves no FIFO entry behind.
    always_comb begin
        stat_hits_d  = stat_hits_q + 32'(out_valid_q && out_ready && !out_last_q);
        stat_drops_d = stat_drops_q + 32'(in_valid && !push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits_q  <= '0;
            stat_drops_q <= '0;
        end else begin
            stat_hits_q  <= stat_hits_d;
            stat_drops_q <= stat_drops_d;
        end
    end

    assign stat_hits  = stat_hits_q;
    assign stat_drops = stat_drops_q;
`else
    assign stat_hits  = '0;
    assign stat_drops = '0;
`endif

endmodule

// File: tb/tb_fpm_hit_extractor.sv
module tb_fpm_hit_extractor;
  localparam int POS_W = 16;
  localparam int EW    = POS_W + 5;  // {pos, bucket, last, trunc}

  logic              clk = 1'b0;
  logic              rst_n;
  logic [255:0]      in_data;
  logic              in_valid, in_sop, in_eop;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [POS_W-1:0]  out_pos;
  logic [2:0]        out_bucket;
  logic              out_last, out_trunc;
  logic [31:0]       stat_hits, stat_drops;

  fpm_hit_extractor #(.FIFO_DEPTH(16), .POS_WIDTH(POS_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pos    (out_pos),
    .out_bucket (out_bucket),
    .out_last   (out_last),
    .out_trunc  (out_trunc),
    .stat_hits  (stat_hits),
    .stat_drops (stat_drops)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];
  int            hs_cyc_q[$];
  bit            log_en = 1'b0;
  int            exp_hits = 0;
  int            exp_drops = 0;
  int            last_e0 = 0;
  int            rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // out_ready changes shortly after the edge, away from the monitor sample
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // ---------------- reference model ----------------
  // Hits of accepted beats in ascending bit order, then one end token.
  task automatic model_packet(input logic [255:0] vecs[$], input int n_acc, input bit trunc);
    for (int b = 0; b < n_acc; b++)
      for (int k = 0; k < 256; k++)
        if (vecs[b][k] == 1'b0)
          exp_q.push_back({POS_W'(b * 32 + k / 8), 3'(k % 8), 1'b0, 1'b0});
    exp_q.push_back({POS_W'(0), 3'd0, 1'b1, trunc});
  endtask

  function automatic logic [255:0] rand_vec(input int kind);
    logic [255:0] v;
    v = '1;
    if (kind == 1) begin
      repeat ($urandom_range(1, 6)) v[$urandom_range(0, 255)] = 1'b0;
    end else if (kind == 2) begin
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    end
    return v;
  endfunction

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_beat(input logic [255:0] v, input logic sop, input logic eop);
    in_data  = v;
    in_sop   = sop;
    in_eop   = eop;
    in_valid = 1'b1;
    last_e0  = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic send_packet(input logic [255:0] vecs[$], input bit gaps);
    model_packet(vecs, vecs.size(), 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      send_beat(vecs[i], i == 0, i == vecs.size() - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [EW:0] snap;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] got, e;
    got = {out_pos, out_bucket, out_last, out_trunc};
    if (rst_n) begin
      if (prev_stall) chk("hold", {out_valid, got}, snap);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h required no output", got);
        end else begin
          e = exp_q.pop_front();
          chk("out", got, e);
          if (!e[1]) exp_hits++;
        end
        if (log_en) hs_cyc_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      snap       = {out_valid, got};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] vecs[$];
    logic [255:0] v;
    int t0, n;

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pos", out_pos, 0);
    chk("rst_bucket", out_bucket, 0);
    chk("rst_last", {out_last, out_trunc}, 0);
    chk("rst_stats", {stat_hits, stat_drops}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_valid", out_valid, 0);

    // single-beat packet, bits 0 and 37, fixed latency
    rdy_mode = 1;
    hs_cyc_q.delete();
    log_en = 1'b1;
    v = '1; v[0] = 1'b0; v[37] = 1'b0;
    vecs.delete(); vecs.push_back(v);
    send_packet(vecs, 1'b0);
    t0 = last_e0;
    wait_drain(100);
    log_en = 1'b0;
    chk("a_hs_count", hs_cyc_q.size(), 3);
    if (hs_cyc_q.size() == 3)
      for (int i = 0; i < 3; i++) chk("a_hs_cycle", hs_cyc_q[i], t0 + 2 + i);

    // 3-beat packet, only bit 255 of beat 2
    vecs.delete();
    vecs.push_back('1); vecs.push_back('1);
    v = '1; v[255] = 1'b0; vecs.push_back(v);
    send_packet(vecs, 1'b0);
    wait_drain(100);

    // backpressure on the first hit
    rdy_mode = 0;
    v = '1; v[10] = 1'b0; v[20] = 1'b0; v[30] = 1'b0;
    vecs.delete(); vecs.push_back(v);
    send_packet(vecs, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("c_first_valid", out_valid, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("c_valid_held", out_valid, 1);
    rdy_mode = 1;
    wait_drain(100);

    // randomized packets with random backpressure
    rdy_mode = 2;
    for (int p = 0; p < 20; p++) begin
      vecs.delete();
      n = $urandom_range(1, 4);
      for (int b = 0; b < n; b++) begin
        int r;
        r = $urandom_range(0, 9);
        vecs.push_back(rand_vec(r < 3 ? 0 : (r < 9 ? 1 : 2)));
      end
      send_packet(vecs, 1'b1);
      wait_drain(3000);
    end

    // all-zero beat: 256 back-to-back hits, then end token
    rdy_mode = 1;
    hs_cyc_q.delete();
    log_en = 1'b1;
    vecs.delete(); vecs.push_back('0);
    send_packet(vecs, 1'b0);
    t0 = last_e0;
    wait_drain(600);
    log_en = 1'b0;
    chk("e_hs_count", hs_cyc_q.size(), 257);
    if (hs_cyc_q.size() == 257) begin
      chk("e_first", hs_cyc_q[0], t0 + 2);
      chk("e_span", hs_cyc_q[255] - hs_cyc_q[0], 255);
      chk("e_token", hs_cyc_q[256] - hs_cyc_q[0], 256);
    end

    // asynchronous reset in the middle of a scan
    vecs.delete(); vecs.push_back('0);
    send_packet(vecs, 1'b0);
    repeat (40) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_hits  = 0;
    exp_drops = 0;
    #1;
    chk("f_rst_valid", out_valid, 0);
    chk("f_rst_pos", out_pos, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vecs.delete();
    v = '1; v[9] = 1'b0; v[100] = 1'b0; vecs.push_back(v);
    v = '1; v[40] = 1'b0; vecs.push_back(v);
    send_packet(vecs, 1'b0);
    wait_drain(100);

    // overflow: FSM parked on an end token, 20 beats then eop
    rdy_mode = 0;
    v = '1; v[3] = 1'b0;
    vecs.delete(); vecs.push_back(v);
    send_packet(vecs, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    vecs.delete();
    for (int b = 0; b < 21; b++) vecs.push_back(rand_vec(1));
    model_packet(vecs, 15, 1'b1);
    for (int b = 0; b < 21; b++) send_beat(vecs[b], b == 0, b == 20);
    exp_drops = 5;
    rdy_mode = 2;
    wait_drain(3000);

`ifdef FPM_HIT_STATS_EN
    chk("stat_hits", stat_hits, exp_hits);
    chk("stat_drops", stat_drops, exp_drops);
`else
    chk("stat_hits", stat_hits, 0);
    chk("stat_drops", stat_drops, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
